bpu_update_scheduler: RTL and testbench

Buffers predictor-training updates produced by the branch/jump unit and sequences them into the BHT write port and the shared BTB array. The BTB port also serves instruction-fetch reads, and fetch reads take priority. The block queues updates, issues each BHT update immediately, and holds each BTB write until the port is free. A starvation counter forces a write slot by holding fetch. It sits between the BJU scoreboard outputs and the BHT/BTB instances in the frontend.

---
 rtl/bpu_update_scheduler_if.sv | 54 +++++
 rtl/bpu_update_scheduler.sv | 150 +++++++++++++++
 tb/tb_bpu_update_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_scheduler_if.sv
// Bundle between the BJU scoreboard, fetch read request and the BHT/BTB write ports.
// The master side produces updates and fetch requests; the slave side is the scheduler.
interface bpu_update_scheduler_if #(
    parameter int BHTBTB_INDEX_WIDTH = 9
);
    logic                          bjusb_bht_write_enable;
    logic                          bjusb_bht_inc;
    logic                          bjusb_bht_dec;
    logic                          bjusb_bht_valid_in;
    logic [BHTBTB_INDEX_WIDTH-1:0] bjusb_bht_write_index;
    logic [1:0]                    bjusb_bht_write_counter_select;
    logic                          bjusb_btb_we;
    logic [128:0]                  bjusb_btb_wmask;
    logic [128:0]                  bjusb_btb_din;
    logic [8:0]                    bjusb_btb_write_index;
    logic                          btb_rd_req;

    logic                          bht_write_enable;
    logic                          bht_write_inc;
    logic                          bht_write_dec;
    logic                          bht_valid_in;
    logic [BHTBTB_INDEX_WIDTH-1:0] bht_write_index;
    logic [1:0]                    bht_write_counter_select;
    logic                          btb_ce;
    logic                          btb_we;
    logic [128:0]                  btb_wmask;
    logic [128:0]                  btb_din;
    logic [8:0]                    btb_write_index;
    logic                          fetch_hold;
    logic                          upd_full;
    logic [15:0]                   drop_cnt;

    modport master (
        output bjusb_bht_write_enable, bjusb_bht_inc, bjusb_bht_dec, bjusb_bht_valid_in,
               bjusb_bht_write_index, bjusb_bht_write_counter_select,
               bjusb_btb_we, bjusb_btb_wmask, bjusb_btb_din, bjusb_btb_write_index,
               btb_rd_req,
        input  bht_write_enable, bht_write_inc, bht_write_dec, bht_valid_in,
               bht_write_index, bht_write_counter_select,
               btb_ce, btb_we, btb_wmask, btb_din, btb_write_index,
               fetch_hold, upd_full, drop_cnt
    );

    modport slave (
        input  bjusb_bht_write_enable, bjusb_bht_inc, bjusb_bht_dec, bjusb_bht_valid_in,
               bjusb_bht_write_index, bjusb_bht_write_counter_select,
               bjusb_btb_we, bjusb_btb_wmask, bjusb_btb_din, bjusb_btb_write_index,
               btb_rd_req,
        output bht_write_enable, bht_write_inc, bht_write_dec, bht_valid_in,
               bht_write_index, bht_write_counter_select,
               btb_ce, btb_we, btb_wmask, btb_din, btb_write_index,
               fetch_hold, upd_full, drop_cnt
    );
endinterface

// File: rtl/bpu_update_scheduler.sv
// Queues BJU predictor updates; issues BHT writes at once and slots BTB writes around
// fetch reads, forcing a slot via fetch_hold after STARVE_LIMIT blocked cycles.
module bpu_update_scheduler #(
    parameter int BHTBTB_INDEX_WIDTH = 9,
    parameter int DEPTH              = 4,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bpu_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic                          bht_en;
        logic [BHTBTB_INDEX_WIDTH-1:0] bht_idx;
        logic [1:0]                    bht_sel;
        logic                          bht_inc;
        logic                          bht_dec;
        logic                          btb_we;
        logic [8:0]                    btb_idx;
        logic [128:0]                  btb_wmask;
        logic [128:0]                  btb_din;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_STALL} state_t;

    entry_t             queue_mem [DEPTH];
    entry_t             head;
    entry_t             new_entry;
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               fetch_hold_q, fetch_hold_d;
    logic [15:0]        drop_q, drop_d;
    logic               req, push, pop, blocked, bht_fire, btb_fire;

    assign req  = bus.bjusb_bht_write_enable | bus.bjusb_btb_we;
    assign push = req && (count_q != DEPTH_C);
    assign head = queue_mem[rd_ptr_q];

    assign new_entry = '{
        bht_en:    bus.bjusb_bht_write_enable,
        bht_idx:   bus.bjusb_bht_write_index,
        bht_sel:   bus.bjusb_bht_write_counter_select,
        bht_inc:   bus.bjusb_bht_inc,
        bht_dec:   bus.bjusb_bht_dec,
        btb_we:    bus.bjusb_btb_we,
        btb_idx:   bus.bjusb_btb_write_index,
        btb_wmask: bus.bjusb_btb_wmask,
        btb_din:   bus.bjusb_btb_din
    };

    always_ff @(posedge clock) begin
        if (push) begin
            queue_mem[wr_ptr_q] <= new_entry;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        blocked  = 1'b0;
        bht_fire = 1'b0;
        btb_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (push) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                bht_fire = head.bht_en;
                if (!head.btb_we) begin
                    pop = 1'b1;
                end else if (!bus.btb_rd_req || fetch_hold_q) begin
                    btb_fire = 1'b1;
                    pop      = 1'b1;
                end else begin
                    blocked = 1'b1;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!bus.btb_rd_req || fetch_hold_q) begin
                    btb_fire = 1'b1;
                    pop      = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (pop) state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;

        // Hold fetch from the edge the counter reaches the limit until the write pops.
        if (pop)                                  starve_d = '0;
        else if (blocked && starve_q != LIMIT_C)  starve_d = starve_q + STV_W'(1);
        else                                      starve_d = starve_q;
        if (pop)                       fetch_hold_d = 1'b0;
        else if (starve_d == LIMIT_C)  fetch_hold_d = 1'b1;
        else                           fetch_hold_d = fetch_hold_q;

        drop_d = (req && !push && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

        bus.bht_write_enable         = bht_fire;
        bus.bht_valid_in             = bht_fire;
        bus.bht_write_inc            = bht_fire & head.bht_inc;
        bus.bht_write_dec            = bht_fire & head.bht_dec;
        bus.bht_write_index          = bht_fire ? head.bht_idx : '0;
        bus.bht_write_counter_select = bht_fire ? head.bht_sel : '0;
        bus.btb_ce                   = btb_fire;
        bus.btb_we                   = btb_fire;
        bus.btb_write_index          = btb_fire ? head.btb_idx : '0;
        bus.btb_wmask                = btb_fire ? head.btb_wmask : '0;
        bus.btb_din                  = btb_fire ? head.btb_din : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            fetch_hold_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            fetch_hold_q <= fetch_hold_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.fetch_hold = fetch_hold_q;
    assign bus.upd_full   = (count_q == DEPTH_C);
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Directed bench for bpu_update_scheduler: inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge against hand-derived values.
module tb_bpu_update_scheduler;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bpu_update_scheduler_if #(.BHTBTB_INDEX_WIDTH(9)) bus_if ();

    bpu_update_scheduler #(
        .BHTBTB_INDEX_WIDTH(9),
        .DEPTH(4),
        .STARVE_LIMIT(4)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    task automatic check_val(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr_upd();
        bus_if.bjusb_bht_write_enable         = 1'b0;
        bus_if.bjusb_bht_inc                  = 1'b0;
        bus_if.bjusb_bht_dec                  = 1'b0;
        bus_if.bjusb_bht_valid_in             = 1'b0;
        bus_if.bjusb_bht_write_index          = '0;
        bus_if.bjusb_bht_write_counter_select = '0;
        bus_if.bjusb_btb_we                   = 1'b0;
        bus_if.bjusb_btb_wmask                = '0;
        bus_if.bjusb_btb_din                  = '0;
        bus_if.bjusb_btb_write_index          = '0;
    endtask

    task automatic set_upd(input logic bht_en, input logic [8:0] bidx, input logic [1:0] sel,
                           input logic inc, input logic dec, input logic btb_we,
                           input logic [8:0] tidx, input logic [128:0] din);
        bus_if.bjusb_bht_write_enable         = bht_en;
        bus_if.bjusb_bht_valid_in             = bht_en;
        bus_if.bjusb_bht_write_index          = bidx;
        bus_if.bjusb_bht_write_counter_select = sel;
        bus_if.bjusb_bht_inc                  = inc;
        bus_if.bjusb_bht_dec                  = dec;
        bus_if.bjusb_btb_we                   = btb_we;
        bus_if.bjusb_btb_write_index          = tidx;
        bus_if.bjusb_btb_wmask                = {129{1'b1}};
        bus_if.bjusb_btb_din                  = din;
        $display("push bht_en=%0b bidx=0x%0h sel=%0d inc=%0b dec=%0b btb_we=%0b tidx=0x%0h",
                 bht_en, bidx, sel, inc, dec, btb_we, tidx);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_upd();
        bus_if.btb_rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        check_val({tag, "_bht_we"}, bus_if.bht_write_enable, 1'b0);
        check_val({tag, "_btb_we"}, bus_if.btb_we, 1'b0);
    endtask

    logic [128:0] din_a;
    logic [128:0] din_b;

    initial begin
        din_a = {1'b1, 64'h0, 32'hDEADBEEF, 32'h0};
        din_b = {1'b0, 64'h0, 32'h00C0FFEE, 32'h0};

        // Reset state
        reset_n = 1'b0;
        clr_upd();
        bus_if.btb_rd_req = 1'b0;
        #2;
        check_val("rst_bht_we", bus_if.bht_write_enable, 1'b0);
        check_val("rst_btb_ce", bus_if.btb_ce, 1'b0);
        check_val("rst_btb_we", bus_if.btb_we, 1'b0);
        check_val("rst_hold", bus_if.fetch_hold, 1'b0);
        check_val("rst_full", bus_if.upd_full, 1'b0);
        check_val("rst_drop", bus_if.drop_cnt, 16'd0);
        do_reset();

        // Single BHT-only update
        step(); set_upd(1'b1, 9'h1A3, 2'd2, 1'b1, 1'b0, 1'b0, 9'h0, '0);
        mid();  chk_quiet("t1_c1");
        step(); clr_upd();
        mid();
        check_val("t1_bht_we", bus_if.bht_write_enable, 1'b1);
        check_val("t1_bht_vld", bus_if.bht_valid_in, 1'b1);
        check_val("t1_bht_idx", bus_if.bht_write_index, 9'h1A3);
        check_val("t1_bht_sel", bus_if.bht_write_counter_select, 2'd2);
        check_val("t1_bht_inc", bus_if.bht_write_inc, 1'b1);
        check_val("t1_bht_dec", bus_if.bht_write_dec, 1'b0);
        check_val("t1_btb_we", bus_if.btb_we, 1'b0);
        step(); mid();
        chk_quiet("t1_c3");
        check_val("t1_count", dut.count_q, 0);
        check_val("t1_state", dut.state_q, 0);

        // BHT+BTB update, fetch busy for two cycles
        do_reset();
        step(); set_upd(1'b1, 9'h0F0, 2'd1, 1'b0, 1'b1, 1'b1, 9'h055, din_a);
        step(); clr_upd(); bus_if.btb_rd_req = 1'b1;
        mid();
        check_val("t2_bht_we", bus_if.bht_write_enable, 1'b1);
        check_val("t2_bht_idx", bus_if.bht_write_index, 9'h0F0);
        check_val("t2_bht_dec", bus_if.bht_write_dec, 1'b1);
        check_val("t2_btb_blk", bus_if.btb_we, 1'b0);
        step(); mid();
        chk_quiet("t2_c3");
        check_val("t2_state_stall", dut.state_q, 2);
        step(); bus_if.btb_rd_req = 1'b0;
        mid();
        check_val("t2_btb_ce", bus_if.btb_ce, 1'b1);
        check_val("t2_btb_we", bus_if.btb_we, 1'b1);
        check_val("t2_btb_idx", bus_if.btb_write_index, 9'h055);
        check_val("t2_btb_din", bus_if.btb_din, din_a);
        check_val("t2_btb_mask", bus_if.btb_wmask, {129{1'b1}});
        check_val("t2_bht_again", bus_if.bht_write_enable, 1'b0);
        check_val("t2_hold", bus_if.fetch_hold, 1'b0);
        step(); mid();
        chk_quiet("t2_c5");

        // Starvation: fetch_hold after four blocked cycles
        do_reset();
        step(); set_upd(1'b0, 9'h0, 2'd0, 1'b0, 1'b0, 1'b1, 9'h1FF, din_b);
        step(); clr_upd(); bus_if.btb_rd_req = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            if (c > 2) step();
            mid();
            check_val($sformatf("t3_hold_c%0d", c), bus_if.fetch_hold, 1'b0);
            check_val($sformatf("t3_btb_c%0d", c), bus_if.btb_we, 1'b0);
        end
        step(); bus_if.btb_rd_req = 1'b0;
        mid();
        check_val("t3_hold_set", bus_if.fetch_hold, 1'b1);
        check_val("t3_btb_we", bus_if.btb_we, 1'b1);
        check_val("t3_btb_idx", bus_if.btb_write_index, 9'h1FF);
        check_val("t3_btb_din", bus_if.btb_din, din_b);
        step(); mid();
        check_val("t3_hold_clr", bus_if.fetch_hold, 1'b0);
        chk_quiet("t3_c7");

        // Overflow: five updates into a four-entry queue
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            set_upd(1'b1, 9'(9'h100 + k), 2'd3, 1'b1, 1'b0, 1'b1, 9'(9'h010 + k), din_b);
            if (k > 0) bus_if.btb_rd_req = 1'b1;
            if (k == 1) begin
                mid();
                check_val("t4_bht_e0", bus_if.bht_write_index, 9'h100);
            end
        end
        mid();
        check_val("t4_full", bus_if.upd_full, 1'b1);
        check_val("t4_hold_pre", bus_if.fetch_hold, 1'b0);
        step(); clr_upd(); bus_if.btb_rd_req = 1'b0;
        mid();
        check_val("t4_drop", bus_if.drop_cnt, 16'd1);
        check_val("t4_hold", bus_if.fetch_hold, 1'b1);
        check_val("t4_btb_e0", bus_if.btb_write_index, 9'h010);
        check_val("t4_btb_we_e0", bus_if.btb_we, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step(); mid();
            check_val($sformatf("t4_bht_e%0d", k), bus_if.bht_write_index, 9'(9'h100 + k));
            check_val($sformatf("t4_btb_e%0d", k), bus_if.btb_write_index, 9'(9'h010 + k));
            check_val($sformatf("t4_btb_we_e%0d", k), bus_if.btb_we, 1'b1);
        end
        step(); mid();
        chk_quiet("t4_no_e4");
        check_val("t4_drop_end", bus_if.drop_cnt, 16'd1);
        check_val("t4_full_end", bus_if.upd_full, 1'b0);

        // Streaming: one push per cycle, no fetch traffic
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            set_upd(1'b1, 9'(9'h040 + k), 2'd0, 1'b0, 1'b1, 1'b1, 9'(9'h020 + k), din_a);
            mid();
            check_val($sformatf("t5_cnt_c%0d", k), dut.count_q <= 1, 1'b1);
            if (k > 0) begin
                check_val($sformatf("t5_btb_e%0d", k - 1), bus_if.btb_write_index, 9'(9'h020 + k - 1));
                check_val($sformatf("t5_bht_e%0d", k - 1), bus_if.bht_write_index, 9'(9'h040 + k - 1));
            end else begin
                check_val("t5_btb_first", bus_if.btb_we, 1'b0);
            end
        end
        step(); clr_upd();
        mid();
        check_val("t5_btb_e5", bus_if.btb_write_index, 9'h025);
        step(); mid();
        chk_quiet("t5_end");
        check_val("t5_drop", bus_if.drop_cnt, 16'd0);

        // Reset while stalled with three entries queued
        do_reset();
        step(); set_upd(1'b1, 9'h077, 2'd1, 1'b1, 1'b0, 1'b1, 9'h033, din_a);
        step(); set_upd(1'b1, 9'h078, 2'd1, 1'b1, 1'b0, 1'b1, 9'h034, din_a);
        bus_if.btb_rd_req = 1'b1;
        step(); set_upd(1'b1, 9'h079, 2'd1, 1'b1, 1'b0, 1'b1, 9'h035, din_a);
        step(); clr_upd();
        mid();
        check_val("t6_pre_state", dut.state_q, 2);
        check_val("t6_pre_count", dut.count_q, 3);
        step();
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_bht_we", bus_if.bht_write_enable, 1'b0);
        check_val("t6_rst_btb_we", bus_if.btb_we, 1'b0);
        check_val("t6_rst_btb_ce", bus_if.btb_ce, 1'b0);
        check_val("t6_rst_hold", bus_if.fetch_hold, 1'b0);
        check_val("t6_rst_count", dut.count_q, 0);
        check_val("t6_rst_state", dut.state_q, 0);
        mid();
        reset_n = 1'b1;
        bus_if.btb_rd_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(); mid();
            chk_quiet($sformatf("t6_post_c%0d", c));
        end
        check_val("t6_state", dut.state_q, 0);
        check_val("t6_drop", bus_if.drop_cnt, 16'd0);
        check_val("t6_full", bus_if.upd_full, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
